// File: rtl/timing_cfg_loader.sv
// Byte-stream loader for pulse/sweep/trigger/calibration timing registers.
// Frames are sync-hunted, checksummed and range-checked before applying.
module timing_cfg_loader #(
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55,
    parameter logic [7:0]  CMD_TIMING  = 8'h01,
    parameter int unsigned GAP_TIMEOUT = 100000,
    parameter logic [31:0] DEF_PULSE   = 32'd100,
    parameter logic [31:0] DEF_SWEEP   = 32'd1000,
    parameter logic [31:0] DEF_YS      = 32'd0,
    parameter logic [63:0] DEF_CT      = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] pulse_clock_num,
    output logic [31:0] sweep_clock_num,
    output logic [31:0] ys_clock_num,
    output logic [63:0] ct_clock_num,
    output logic        update,
    output logic        cfg_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_HUNT0,
        S_HUNT1,
        S_CMD,
        S_PAYLOAD,
        S_CHK,
        S_APPLY
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     csum_q, csum_d;
    logic [159:0]   stage_q, stage_d;
    logic [31:0]    gap_q, gap_d;
    logic [31:0]    pulse_q, pulse_d;
    logic [31:0]    sweep_q, sweep_d;
    logic [31:0]    ys_q, ys_d;
    logic [63:0]    ct_q, ct_d;
    logic           update_q, update_d;
    logic           cfg_err_q, cfg_err_d;
    logic [1:0]     err_code_q, err_code_d;
    logic           pend_q, pend_d;
    logic [1:0]     pend_code_q, pend_code_d;

    logic [31:0]    st_pulse, st_sweep, st_ys;
    logic [63:0]    st_ct;
    logic           range_ok;
    logic           timeout;

    assign st_pulse = stage_q[159:128];
    assign st_sweep = stage_q[127:96];
    assign st_ys    = stage_q[95:64];
    assign st_ct    = stage_q[63:0];

    assign range_ok = (st_pulse != 32'd0) && (st_sweep != 32'd0) &&
                      (st_pulse < st_sweep);

    assign timeout = (state_q != S_HUNT0) &&
                     (gap_q == 32'(GAP_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        stage_d     = stage_q;
        pulse_d     = pulse_q;
        sweep_d     = sweep_q;
        ys_d        = ys_q;
        ct_d        = ct_q;
        update_d    = 1'b0;
        pend_d      = 1'b0;
        pend_code_d = pend_code_q;
        // Rejections are delayed one cycle so cfg_err lines up with update.
        cfg_err_d   = pend_q;
        err_code_d  = pend_q ? pend_code_q : err_code_q;

        if (state_q == S_HUNT0 || rx_valid) begin
            gap_d = 32'd0;
        end else begin
            gap_d = gap_q + 32'd1;
        end

        if (timeout) begin
            state_d = S_HUNT0;
            gap_d   = 32'd0;
        end else begin
            unique case (state_q)
                S_HUNT0: begin
                    if (rx_valid && rx_data == HDR0) begin
                        state_d = S_HUNT1;
                    end
                end
                S_HUNT1: begin
                    if (rx_valid) begin
                        if (rx_data == HDR1) begin
                            state_d = S_CMD;
                        end else if (rx_data != HDR0) begin
                            state_d = S_HUNT0;
                        end
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_TIMING) begin
                            state_d = S_PAYLOAD;
                            idx_d   = 5'd0;
                            csum_d  = rx_data;
                        end else begin
                            state_d     = S_HUNT0;
                            pend_d      = 1'b1;
                            pend_code_d = 2'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        stage_d = {stage_q[151:0], rx_data};
                        csum_d  = csum_q ^ rx_data;
                        if (idx_q == 5'd19) begin
                            state_d = S_CHK;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data != csum_q) begin
                            state_d     = S_HUNT0;
                            pend_d      = 1'b1;
                            pend_code_d = 2'd2;
                        end else if (!range_ok) begin
                            state_d     = S_HUNT0;
                            pend_d      = 1'b1;
                            pend_code_d = 2'd3;
                        end else begin
                            state_d = S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    pulse_d  = st_pulse;
                    sweep_d  = st_sweep;
                    ys_d     = st_ys;
                    ct_d     = st_ct;
                    update_d = 1'b1;
                    state_d  = S_HUNT0;
                end
                default: begin
                    state_d = S_HUNT0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_HUNT0;
            idx_q       <= 5'd0;
            csum_q      <= 8'd0;
            stage_q     <= 160'd0;
            gap_q       <= 32'd0;
            pulse_q     <= DEF_PULSE;
            sweep_q     <= DEF_SWEEP;
            ys_q        <= DEF_YS;
            ct_q        <= DEF_CT;
            update_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_code_q  <= 2'd0;
            pend_q      <= 1'b0;
            pend_code_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            stage_q     <= stage_d;
            gap_q       <= gap_d;
            pulse_q     <= pulse_d;
            sweep_q     <= sweep_d;
            ys_q        <= ys_d;
            ct_q        <= ct_d;
            update_q    <= update_d;
            cfg_err_q   <= cfg_err_d;
            err_code_q  <= err_code_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
        end
    end

    assign pulse_clock_num = pulse_q;
    assign sweep_clock_num = sweep_q;
    assign ys_clock_num    = ys_q;
    assign ct_clock_num    = ct_q;
    assign update          = update_q;
    assign cfg_err         = cfg_err_q;
    assign err_code        = err_code_q;
    assign busy            = (state_q != S_HUNT0);

endmodule

// File: tb/tb_timing_cfg_loader.sv
// Scoreboard bench for timing_cfg_loader: frame-level reference model,
// expected events queued by the stimulus and popped by a monitor.
module tb_timing_cfg_loader;

    localparam int G = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] pulse_clock_num;
    logic [31:0] sweep_clock_num;
    logic [31:0] ys_clock_num;
    logic [63:0] ct_clock_num;
    logic        update;
    logic        cfg_err;
    logic [1:0]  err_code;
    logic        busy;

    timing_cfg_loader #(.GAP_TIMEOUT(G)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .pulse_clock_num (pulse_clock_num),
        .sweep_clock_num (sweep_clock_num),
        .ys_clock_num    (ys_clock_num),
        .ct_clock_num    (ct_clock_num),
        .update          (update),
        .cfg_err         (cfg_err),
        .err_code        (err_code),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int          at;
        logic [31:0] p, s, y;
        logic [63:0] c;
    } ev_t;

    ev_t q[$];
    int errors = 0;
    int checks = 0;

    logic [31:0] m_p = 32'd100;
    logic [31:0] m_s = 32'd1000;
    logic [31:0] m_y = 32'd0;
    logic [63:0] m_c = 64'd0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_err, input logic [1:0] code);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.at     = cyc + 1;
        e.p      = m_p;
        e.s      = m_s;
        e.y      = m_y;
        e.c      = m_c;
        q.push_back(e);
    endtask

    ev_t me;
    always @(negedge clk) begin
        if (update || cfg_err) begin
            chk("update_and_err", 64'(update && cfg_err), 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: update=%0b cfg_err=%0b cycle %0d",
                         update, cfg_err, cyc);
            end else begin
                me = q.pop_front();
                chk("event_kind", 64'(cfg_err), 64'(me.is_err));
                chk("event_cycle", 64'(cyc), 64'(me.at));
                if (me.is_err) chk("err_code", 64'(err_code), 64'(me.code));
                chk("pulse", 64'(pulse_clock_num), 64'(me.p));
                chk("sweep", 64'(sweep_clock_num), 64'(me.s));
                chk("ys", 64'(ys_clock_num), 64'(me.y));
                chk("ct", ct_clock_num, me.c);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (gap > 0) idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] cmd,
                              input logic [31:0] p, s, y,
                              input logic [63:0] c,
                              input logic [7:0] flip, input int gmax);
        logic [159:0] v;
        logic [7:0]   x;
        v = {p, s, y, c};
        x = cmd;
        send_byte(8'hAA, $urandom_range(0, gmax));
        send_byte(8'h55, $urandom_range(0, gmax));
        if (cmd != 8'h01) begin
            send_byte(cmd, 0);
            push(1'b1, 2'd1);
            idle(2);
            return;
        end
        send_byte(cmd, $urandom_range(0, gmax));
        for (int i = 0; i < 20; i++) begin
            x = x ^ v[159 - 8*i -: 8];
            send_byte(v[159 - 8*i -: 8], $urandom_range(0, gmax));
        end
        send_byte(x ^ flip, 0);
        if (flip != 8'h00) begin
            push(1'b1, 2'd2);
        end else if (!(p != 0 && s != 0 && p < s)) begin
            push(1'b1, 2'd3);
        end else begin
            m_p = p;
            m_s = s;
            m_y = y;
            m_c = c;
            push(1'b0, 2'd0);
        end
        idle(2);
    endtask

    task automatic check_reset_state();
        chk("rst_pulse", 64'(pulse_clock_num), 64'd100);
        chk("rst_sweep", 64'(sweep_clock_num), 64'd1000);
        chk("rst_ys", 64'(ys_clock_num), 64'd0);
        chk("rst_ct", ct_clock_num, 64'd0);
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] p, s;
        logic [7:0]  f, cm;
        int cat;

        rst = 1'b0;
        idle(3);
        check_reset_state();
        rst = 1'b1;
        idle(2);

        send_frame(8'h01, 32'h64, 32'h3E8, 32'h10, 64'h1_0000_0000, 8'h00, 0);
        send_frame(8'h01, 32'h65, 32'h3E9, 32'h11, 64'h2_0000_0000, 8'h01, 0);
        send_frame(8'h01, 32'd1000, 32'd1000, 32'h5, 64'h7, 8'h00, 1);
        send_frame(8'h02, 32'd1, 32'd2, 32'd3, 64'd4, 8'h00, 0);

        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        send_byte(8'hAA, 0);
        send_frame(8'h01, 32'd7, 32'd77, 32'd777, 64'hDEAD_BEEF_0123, 8'h00, 0);

        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        idle(G - 1);
        chk("busy_before_timeout", 64'(busy), 64'd1);
        idle(2);
        chk("busy_after_timeout", 64'(busy), 64'd0);
        send_frame(8'h01, 32'd20, 32'd300, 32'd4, 64'd55, 8'h00, 2);

        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom) & 8'h7F, 0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        m_p = 32'd100;
        m_s = 32'd1000;
        m_y = 32'd0;
        m_c = 64'd0;
        check_reset_state();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom) & 8'h7F, 0);
        idle(3);
        send_frame(8'h01, 32'd9, 32'd10, 32'd11, 64'd12, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--)
                send_byte(8'($urandom) & 8'h7F, $urandom_range(0, 2));
            cat = $urandom_range(0, 3);
            p = $urandom_range(1, 1000000);
            s = p + $urandom_range(1, 1000000);
            f = 8'h00;
            cm = 8'h01;
            if (cat == 1) begin
                p = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                s = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            end else if (cat == 2) begin
                f = 8'($urandom_range(1, 255));
            end else if (cat == 3) begin
                cm = 8'($urandom_range(2, 255));
            end
            send_frame(cm, p, s, $urandom, {$urandom, $urandom}, f, 3);
        end

        idle(5);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("final_pulse", 64'(pulse_clock_num), 64'(m_p));
        chk("final_sweep", 64'(sweep_clock_num), 64'(m_s));
        chk("final_ys", 64'(ys_clock_num), 64'(m_y));
        chk("final_ct", ct_clock_num, m_c);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_cfg_loader.md
TIMING_CFG_LOADER -- requirements
Module: timing_cfg_loader

Interface
REQ-001 The block SHALL have parameter HDR0, default 8'hAA, first frame-sync byte.
REQ-002 The block SHALL have parameter HDR1, default 8'h55, second frame-sync byte.
REQ-003 The block SHALL have parameter CMD_TIMING, default 8'h01, the only accepted command code.
REQ-004 The block SHALL have parameter GAP_TIMEOUT, default 100000, the maximum number of clocks allowed between bytes inside a frame.
REQ-005 The block SHALL have parameters DEF_PULSE = 100, DEF_SWEEP = 1000, DEF_YS = 0 and DEF_CT = 0, giving the reset values of the outputs.
REQ-006 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 rx_data  in  8  received byte.
REQ-009 rx_valid  in  1  rx_data is valid this cycle; single-cycle strobe; no backpressure.
REQ-010 pulse_clock_num  out  32  pulse width in clocks.
REQ-011 sweep_clock_num  out  32  sweep period in clocks.
REQ-012 ys_clock_num  out  32  trigger delay in clocks.
REQ-013 ct_clock_num  out  64  calibration time in clocks.
REQ-014 update  out  1  one-cycle pulse; the outputs above carry new values.
REQ-015 cfg_err  out  1  one-cycle pulse; a frame was rejected.
REQ-016 err_code  out  2  reason for the last rejection: 1 = bad command, 2 = checksum, 3 = range; holds its value until the next rejection.
REQ-017 busy  out  1  high in every state except HUNT0.

Function
REQ-018 The frame format SHALL be: HDR0, HDR1, CMD, 20 payload bytes, CHK (24 bytes in total).
REQ-019 The payload SHALL be, in order and each field big-endian: pulse (4 bytes), sweep (4 bytes), ys (4 bytes), ct (8 bytes).
REQ-020 CHK SHALL equal the XOR of CMD and all 20 payload bytes.
REQ-021 FSM states SHALL be HUNT0, HUNT1, CMD, PAYLOAD, CHK, APPLY; all transitions SHALL occur only on cycles with rx_valid=1, except APPLY and timeout.
REQ-022 HUNT0: on byte == HDR0 -> HUNT1; on any other byte -> stay in HUNT0.
REQ-023 HUNT1: on byte == HDR1 -> CMD; on byte == HDR0 -> stay in HUNT1; on any other byte -> HUNT0.
REQ-024 CMD: on byte == CMD_TIMING -> PAYLOAD, clear the 5-bit byte index and load the running XOR with the byte.
REQ-025 CMD: on any other byte -> HUNT0, with cfg_err=1 and err_code=1 in the next cycle.
REQ-026 PAYLOAD: each byte SHALL be shifted into staging registers and XORed into the checksum; after byte index 19 -> CHK.
REQ-027 Staging registers SHALL NOT drive the outputs.
REQ-028 CHK: on byte != running XOR -> HUNT0, with cfg_err=1 and err_code=2 next cycle.
REQ-029 CHK: on match, the staged values SHALL be range-checked: pulse != 0, sweep != 0 and pulse < sweep (unsigned 32-bit compare).
REQ-030 CHK: a failed range check -> HUNT0, with cfg_err=1 and err_code=3 next cycle.
REQ-031 CHK: a passed range check -> APPLY.
REQ-032 APPLY: lasts exactly one cycle; all four outputs SHALL load from staging and update=1 in that same cycle; then -> HUNT0.
REQ-033 Latency: with the CHK byte accepted at edge N, the new outputs and update=1 SHALL be visible after edge N+1.
REQ-034 Latency: cfg_err SHALL follow the same N+1 timing as update.
REQ-035 Outputs SHALL change only in APPLY; a rejected or aborted frame leaves them unchanged.
REQ-036 Gap timeout: in any state other than HUNT0, a 32-bit counter SHALL clear on each accepted byte and increment otherwise.
REQ-037 Gap timeout: on count == GAP_TIMEOUT -> HUNT0 silently, with no cfg_err.
REQ-038 rx_valid high during APPLY SHALL be ignored, and that byte is lost.
REQ-039 update and cfg_err SHALL never be high in the same cycle.

Reset
REQ-040 While rst=0: state = HUNT0; outputs = DEF_*; update=0, cfg_err=0, err_code=0, busy=0; staging, index, checksum and timeout counter cleared.
REQ-041 A reset asserted mid-frame SHALL discard the partial frame, and no update occurs.

Verification
REQ-042 Valid frame, pulse=0x64, sweep=0x3E8, ys=0x10, ct=0x1_0000_0000 with correct CHK -> one update pulse one cycle after CHK; outputs equal those values.
REQ-043 Same frame with CHK XOR 0x01 -> cfg_err pulse, err_code=2; outputs keep the previous values; no update.
REQ-044 Frame with pulse=1000, sweep=1000 -> cfg_err, err_code=3; frame with CMD=0x02 -> cfg_err, err_code=1 at the CMD byte + 1 cycle.
REQ-045 Byte stream AA AA 55 followed by a valid frame body -> frame accepted; stray bytes 12 34 before AA -> ignored.
REQ-046 Stop after payload byte 7 and wait GAP_TIMEOUT clocks -> busy falls, no cfg_err; a subsequent full valid frame -> update.
REQ-047 Assert rst=0 for 1 cycle mid-payload -> outputs = DEF_*; the remaining bytes of that frame produce no update.
